// File: rtl/hwjsoc_oci_dct_pkg.sv
// Shared constants and atom encodings for the OCI debug-control-trace word packer.
package hwjsoc_oci_dct_pkg;

    localparam int ATOM_W = 2;
    localparam int SLOTS  = 15;
    localparam int BUF_W  = ATOM_W * SLOTS;
    localparam int CNT_W  = 4;
    localparam int DROP_W = 16;

    typedef enum logic [ATOM_W-1:0] {
        ATOM_NONE      = 2'b00,
        ATOM_TAKEN     = 2'b01,
        ATOM_NOT_TAKEN = 2'b10,
        ATOM_EXCEPTION = 2'b11
    } atom_e;

endpackage

// File: rtl/hwjsoc_oci_dct_outreg.sv
// Valid/ready holding register for packed DCT words: loads a word, holds it
// until the consumer takes it, and reports when a new word may be loaded.
module hwjsoc_oci_dct_outreg
    import hwjsoc_oci_dct_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [BUF_W-1:0] load_buffer,
    input  logic [CNT_W-1:0] load_count,
    input  logic             dct_ready,
    output logic             dct_valid,
    output logic [BUF_W-1:0] dct_buffer,
    output logic [CNT_W-1:0] dct_count,
    output logic             out_free
);

    assign out_free = !dct_valid || dct_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dct_valid  <= 1'b0;
            dct_buffer <= '0;
            dct_count  <= '0;
        end else if (load) begin
            dct_valid  <= 1'b1;
            dct_buffer <= load_buffer;
            dct_count  <= load_count;
        end else if (out_free) begin
            // Word consumed (or none present); data fields keep their last value.
            dct_valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/hwjsoc_oci_dct_packer.sv
// Packs 2-bit OCI trace atoms into 30-bit words with flush and end-of-test drain.
// Optional lossy mode with a saturating drop counter: define DCT_DROP_COUNT_EN.
module hwjsoc_oci_dct_packer
    import hwjsoc_oci_dct_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              atom_valid,
    input  logic [ATOM_W-1:0] atom,
    output logic              atom_ready,
    input  logic              flush,
    input  logic              test_ending,
    output logic              dct_valid,
    input  logic              dct_ready,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              test_has_ended,
    output logic [DROP_W-1:0] dct_dropped
);

    logic [BUF_W-1:0] acc;
    logic [CNT_W-1:0] acc_cnt;
    logic             flush_pend;
    logic             out_free;
    logic             acc_full;
    logic             acc_empty;
    logic             accept;
    logic             xfer;

    assign acc_full  = (acc_cnt == CNT_W'(SLOTS));
    assign acc_empty = (acc_cnt == '0);

`ifdef DCT_DROP_COUNT_EN
    // Producer is never stalled; an atom that finds no room is discarded.
    assign atom_ready = 1'b1;
    assign accept     = atom_valid && (!acc_full || out_free);
`else
    assign atom_ready = !acc_full || out_free;
    assign accept     = atom_valid && atom_ready;
`endif

    assign xfer = out_free && (acc_full || (flush_pend && !acc_empty));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc            <= '0;
            acc_cnt        <= '0;
            flush_pend     <= 1'b0;
            test_has_ended <= 1'b0;
        end else begin
            if (xfer) begin
                acc     <= accept ? {{(BUF_W-ATOM_W){1'b0}}, atom} : '0;
                acc_cnt <= accept ? CNT_W'(1) : '0;
            end else if (accept) begin
                acc     <= {acc[BUF_W-ATOM_W-1:0], atom};
                acc_cnt <= acc_cnt + CNT_W'(1);
            end

            // A pending flush never outlives an empty accumulator, so no empty word is sent.
            if (xfer)
                flush_pend <= 1'b0;
            else if (acc_empty && !accept)
                flush_pend <= 1'b0;
            else if (flush || test_ending)
                flush_pend <= 1'b1;

            if (test_ending && acc_empty && !flush_pend && !dct_valid)
                test_has_ended <= 1'b1;
        end
    end

    hwjsoc_oci_dct_outreg u_outreg (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (xfer),
        .load_buffer (acc),
        .load_count  (acc_cnt),
        .dct_ready   (dct_ready),
        .dct_valid   (dct_valid),
        .dct_buffer  (dct_buffer),
        .dct_count   (dct_count),
        .out_free    (out_free)
    );

`ifdef DCT_DROP_COUNT_EN
    logic drop;
    assign drop = atom_valid && acc_full && !out_free;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            dct_dropped <= '0;
        else if (drop && (dct_dropped != {DROP_W{1'b1}}))
            dct_dropped <= dct_dropped + DROP_W'(1);
    end
`else
    assign dct_dropped = '0;
`endif

endmodule

// File: tb/tb_hwjsoc_oci_dct_packer.sv
// Self-checking bench for hwjsoc_oci_dct_packer: directed scenarios plus random
// traffic, compared every cycle against a queue-based model of the packing rules.
module tb_hwjsoc_oci_dct_packer;
    import hwjsoc_oci_dct_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              atom_valid;
    logic [ATOM_W-1:0] atom;
    logic              atom_ready;
    logic              flush;
    logic              test_ending;
    logic              dct_valid;
    logic              dct_ready;
    logic [BUF_W-1:0]  dct_buffer;
    logic [CNT_W-1:0]  dct_count;
    logic              test_has_ended;
    logic [DROP_W-1:0] dct_dropped;

    int checks = 0;
    int errors = 0;

    // Reference model state: pending atoms oldest-first, plus the presented word.
    logic [1:0] m_acc[$];
    logic       m_valid;
    logic [31:0] m_buf;
    int         m_cnt;
    logic       m_pend;
    logic       m_the;
    int         m_drop;

    hwjsoc_oci_dct_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .atom_valid     (atom_valid),
        .atom           (atom),
        .atom_ready     (atom_ready),
        .flush          (flush),
        .test_ending    (test_ending),
        .dct_valid      (dct_valid),
        .dct_ready      (dct_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_has_ended (test_has_ended),
        .dct_dropped    (dct_dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack_word();
        logic [31:0] v = '0;
        foreach (m_acc[i]) v = (v << 2) | 32'(m_acc[i]);
        return v;
    endfunction

    task automatic reset_model();
        m_acc.delete();
        m_valid = 1'b0;
        m_buf   = '0;
        m_cnt   = 0;
        m_pend  = 1'b0;
        m_the   = 1'b0;
        m_drop  = 0;
    endtask

    // Called just after a falling edge: drive, compare, advance model, wait one cycle.
    task automatic cycle(input logic v, input logic [1:0] a, input logic fl,
                         input logic te, input logic rdy);
        logic full, out_free, exp_ready, acc_ok, lost, xfer, was_empty;
        atom_valid  = v;
        atom        = a;
        flush       = fl;
        test_ending = te;
        dct_ready   = rdy;
        #1;
        full     = (m_acc.size() == SLOTS);
        out_free = !m_valid || rdy;
`ifdef DCT_DROP_COUNT_EN
        exp_ready = 1'b1;
`else
        exp_ready = !full || out_free;
`endif
        chk("atom_ready",     32'(atom_ready),     32'(exp_ready));
        chk("dct_valid",      32'(dct_valid),      32'(m_valid));
        chk("dct_buffer",     32'(dct_buffer),     m_buf);
        chk("dct_count",      32'(dct_count),      32'(m_cnt));
        chk("test_has_ended", 32'(test_has_ended), 32'(m_the));
        chk("dct_dropped",    32'(dct_dropped),    32'(m_drop));

        acc_ok    = v && (!full || out_free);
        lost      = v && full && !out_free;
        was_empty = (m_acc.size() == 0);
        xfer      = out_free && (full || (m_pend && !was_empty));
        if (te && was_empty && !m_pend && !m_valid) m_the = 1'b1;
        if (xfer) begin
            m_buf   = pack_word();
            m_cnt   = m_acc.size();
            m_valid = 1'b1;
            m_acc.delete();
        end else if (out_free) begin
            m_valid = 1'b0;
        end
        if (acc_ok) m_acc.push_back(a);
        if (xfer) m_pend = 1'b0;
        else if (was_empty && !acc_ok) m_pend = 1'b0;
        else if (fl || te) m_pend = 1'b1;
`ifdef DCT_DROP_COUNT_EN
        if (lost && m_drop != 65535) m_drop++;
`else
        if (lost) m_drop = m_drop;
`endif
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_model();
        reset_n = 1'b0;
        atom_valid = 1'b0; atom = '0; flush = 1'b0; test_ending = 1'b0; dct_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset dct_valid",  32'(dct_valid),      32'd0);
        chk("reset dct_buffer", 32'(dct_buffer),     32'd0);
        chk("reset dct_count",  32'(dct_count),      32'd0);
        chk("reset the",        32'(test_has_ended), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Full word of TAKEN atoms at full rate.
        for (int i = 0; i < 15; i++) cycle(1'b1, ATOM_TAKEN, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, ATOM_NONE, 1'b0, 1'b0, 1'b1);
        chk("full word valid", 32'(dct_valid),  32'd1);
        chk("full word data",  32'(dct_buffer), 32'h15555555);
        chk("full word count", 32'(dct_count),  32'd15);
        repeat (3) cycle(1'b0, ATOM_NONE, 1'b0, 1'b0, 1'b1);

        // Partial word via flush, then flush on an empty accumulator.
        cycle(1'b1, ATOM_NOT_TAKEN, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, ATOM_EXCEPTION, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, ATOM_TAKEN,     1'b0, 1'b0, 1'b1);
        cycle(1'b0, ATOM_NONE,      1'b1, 1'b0, 1'b1);
        cycle(1'b0, ATOM_NONE,      1'b0, 1'b0, 1'b1);
        chk("flush word count", 32'(dct_count), 32'd3);
        repeat (3) cycle(1'b0, ATOM_NONE, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, ATOM_NONE, 1'b1, 1'b0, 1'b1);
        repeat (4) cycle(1'b0, ATOM_NONE, 1'b0, 1'b0, 1'b1);

        // Backpressure: 31 atoms with the consumer stalled, then release.
        for (int i = 1; i <= 30; i++) cycle(1'b1, 2'(i), 1'b0, 1'b0, 1'b0);
`ifndef DCT_DROP_COUNT_EN
        chk("stall atom_ready", 32'(atom_ready), 32'd0);
`endif
        cycle(1'b1, 2'(31), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 2'(31), 1'b0, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, ATOM_NONE, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, ATOM_NONE, 1'b1, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, ATOM_NONE, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset with a word held and 7 atoms accumulated.
        for (int i = 0; i < 22; i++) cycle(1'b1, 2'(i + 1), 1'b0, 1'b0, 1'b0);
        chk("pre-reset valid", 32'(dct_valid), 32'd1);
        atom_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async dct_valid",  32'(dct_valid),  32'd0);
        chk("async dct_buffer", 32'(dct_buffer), 32'd0);
        chk("async dct_count",  32'(dct_count),  32'd0);
        reset_model();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        cycle(1'b0, ATOM_NONE, 1'b1, 1'b0, 1'b1);
        repeat (4) cycle(1'b0, ATOM_NONE, 1'b0, 1'b0, 1'b1);

        // Random traffic with occasional flushes and stalls.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 15) == 0,
                  1'b0, $urandom_range(0, 3) != 0);
        cycle(1'b0, ATOM_NONE, 1'b1, 1'b0, 1'b1);
        repeat (20) cycle(1'b0, ATOM_NONE, 1'b0, 1'b0, 1'b1);

        // End-of-test drain with 5 atoms pending.
        for (int i = 0; i < 5; i++) cycle(1'b1, 2'(i), 1'b0, 1'b0, 1'b1);
        repeat (8) cycle(1'b0, ATOM_NONE, 1'b0, 1'b1, 1'b1);
        chk("drained the", 32'(test_has_ended), 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'(i), 1'b0, 1'b0, 1'b1);
        cycle(1'b0, ATOM_NONE, 1'b1, 1'b0, 1'b1);
        repeat (4) cycle(1'b0, ATOM_NONE, 1'b0, 1'b0, 1'b1);
        chk("sticky the", 32'(test_has_ended), 32'd1);

`ifdef DCT_DROP_COUNT_EN
        reset_n = 1'b0;
        reset_model();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 40; i++) cycle(1'b1, 2'(i), 1'b0, 1'b0, 1'b0);
        chk("dropped count", 32'(dct_dropped), 32'd10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
